// File: rtl/tdm_pkg.sv
// Shared types and constants for the 8-to-1 TDM multiplexer.
//   state_t  : controller state (IDLE waits for START, SCAN sends slots)
//   CHANNELS : channel slots per frame (power of two, matches ADDR_W)
//   ADDR_W   : width of the slot address driven on A2..A0
//   DWELL_W  : width of the per-slot dwell counter (dwell up to 16 cycles)
package tdm_pkg;

  localparam int CHANNELS = 8;
  localparam int ADDR_W   = 3;
  localparam int DWELL_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot timing for the TDM multiplexer: a dwell counter that holds each
// slot for DWELL cycles, and an address counter that steps through the
// CHANNELS slots of a frame.
//   CLK, RST_N : clock, asynchronous active-low reset
//   clear      : force dwell and address back to zero (wins over run)
//   run        : advance the dwell counter this cycle
//   addr       : current slot address
//   slot_end   : last dwell cycle of the current slot while running
//   frame_end  : last dwell cycle of the last slot while running
// The address wraps naturally from CHANNELS-1 to 0, which gives the
// gap-free frame-to-frame transition in continuous mode.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              clear,
  input  logic              run,
  output logic [ADDR_W-1:0] addr,
  output logic              slot_end,
  output logic              frame_end
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(CHANNELS - 1);

  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  assign slot_end  = run && (dwell_q == DWELL_LAST);
  assign frame_end = slot_end && (addr_q == ADDR_LAST);
  assign addr      = addr_q;

  always_comb begin
    dwell_d = dwell_q;
    addr_d  = addr_q;
    if (clear) begin
      dwell_d = '0;
      addr_d  = '0;
    end else if (run) begin
      if (slot_end) begin
        dwell_d = '0;
        addr_d  = addr_q + ADDR_W'(1);
      end else begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dwell_q <= '0;
      addr_q  <= '0;
    end else begin
      dwell_q <= dwell_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: rtl/tdm_multiplexer.sv
// 8-to-1 time-division multiplexer: snapshots F and sends one channel bit
// per slot on D with the slot address on A2..A0 (A2 = MSB).
//   CLK, RST_N : clock, asynchronous active-low reset
//   EN         : active-low enable; 1 tri-states D and aborts any frame
//   START      : one-cycle frame request, honoured only in IDLE with EN = 0
//   MODE       : 0 = single frame, 1 = continuous; latched at frame start
//   F          : parallel channel data, F[i] is channel i
//   D          : serial data (high-Z while EN = 1)
//   A2..A0     : current slot address
//   FRAME      : high during every cycle of slot 0
//   BUSY       : high while scanning
//   DONE       : one-cycle pulse after the last slot of a single frame
// Request/completion handshake: START is a request that is accepted only
// on an edge where the block is idle (BUSY = 0) and EN = 0; it is never
// queued. BUSY rises the cycle after acceptance and, for a single frame,
// falls in the same cycle DONE pulses. An abort (EN = 1) or reset drops
// BUSY without a DONE pulse.
module tdm_multiplexer #(
  parameter int CHANNELS = 8,
  parameter int DWELL    = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic                START,
  input  logic                MODE,
  input  logic [CHANNELS-1:0] F,
  output logic                D,
  output logic                A2,
  output logic                A1,
  output logic                A0,
  output logic                FRAME,
  output logic                BUSY,
  output logic                DONE
);

  import tdm_pkg::*;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] snap_q, snap_d;
  logic                mode_q, mode_d;
  logic                frame_q, frame_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                cnt_clear, cnt_run;
  logic                slot_end, frame_end;
  logic [ADDR_W-1:0]   addr, addr_next;
  logic                d_bit;

  // The counter only advances while scanning with the link enabled; an
  // EN = 1 cycle in SCAN is the abort cycle and must not advance it.
  assign cnt_run = (state_q == SCAN) && !EN;

  tdm_slot_counter #(
    .DWELL(DWELL)
  ) u_slot_counter (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clear    (cnt_clear),
    .run      (cnt_run),
    .addr     (addr),
    .slot_end (slot_end),
    .frame_end(frame_end)
  );

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        if (START && !EN) begin
          state_d = SCAN;
          snap_d  = F;
          mode_d  = MODE;
        end
      end
      SCAN: begin
        if (EN) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end else if (frame_end) begin
          if (mode_q) begin
            // Back-to-back frame: fresh snapshot, address wraps to 0.
            snap_d = F;
            mode_d = MODE;
          end else begin
            state_d   = IDLE;
            done_d    = 1'b1;
            cnt_clear = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_clear = 1'b1;
      end
    endcase

    // Address the counter will hold after this edge, so FRAME can be
    // registered in step with A2..A0.
    if (cnt_clear) begin
      addr_next = '0;
    end else if (slot_end) begin
      addr_next = addr + ADDR_W'(1);
    end else begin
      addr_next = addr;
    end
    busy_d  = (state_d == SCAN);
    frame_d = busy_d && (addr_next == '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      snap_q  <= '0;
      mode_q  <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      mode_q  <= mode_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Idle holds D low even though the snapshot keeps the last frame's data.
  assign d_bit = busy_q & snap_q[addr];
  assign D     = EN ? 1'bz : d_bit;

  assign A2    = addr[2];
  assign A1    = addr[1];
  assign A0    = addr[0];
  assign FRAME = frame_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: doc/tdm_multiplexer.md
Name: tdm_multiplexer

Overview:
- 8-to-1 time-division multiplexer: the transmit end of the addressed serial channel whose receive end is the team's 1-to-8 demultiplexer.
- Snapshots eight parallel channel bits and sends them one at a time on D, with the channel address on A2..A0.
- Uses the same active-low EN convention as the demultiplexer, so one EN net gates both ends of the link.

Parameters:
- CHANNELS, 8, number of channel slots per frame; must be a power of two and is fixed at 8 for the 3-bit address.
- DWELL, 1, clock cycles each channel slot is held on D/A2..A0; legal range 1..16.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- EN  input  1  active-low enable. 1 = disabled: D goes high-Z and any frame in progress is aborted.
- START  input  1  single-cycle frame request; sampled only in IDLE.
- MODE  input  1  0 = single frame, 1 = continuous frames; sampled at each frame start.
- F  input  8  parallel channel data, F[i] = channel i.
- D  output  1  serial data; high-Z while EN = 1.
- A2, A1, A0  output  1 each  current slot address, A2 = MSB.
- FRAME  output  1  high during every cycle of slot 0.
- BUSY  output  1  high while in SCAN.
- DONE  output  1  one-cycle pulse after the last slot of a single-mode frame.

Behaviour:
- Reset (RST_N = 0, asynchronous):
  - state = IDLE, snapshot = 0, address = 0, dwell counter = 0, MODE latch = 0.
  - Outputs: A2..A0 = 0, FRAME = 0, BUSY = 0, DONE = 0.
  - D = 0 if EN = 0, high-Z if EN = 1.
- Output timing:
  - A2..A0, FRAME, BUSY and DONE are registered.
  - D is the registered bit snapshot[addr], gated combinationally by EN to high-Z.
- IDLE:
  - Outputs: D = 0 (EN = 0), A = 0, BUSY = 0, FRAME = 0.
  - START = 1 with EN = 0 at a rising edge:
    - latch F into the snapshot and latch MODE;
    - go to SCAN with addr = 0, dwell = 0.
  - The next cycle shows BUSY = 1, FRAME = 1, A = 000 and D = F[0] as captured. Start latency is 1 cycle.
- SCAN:
  - Each slot lasts exactly DWELL cycles; dwell counts 0..DWELL-1.
  - At dwell = DWELL-1, addr increments and dwell clears.
  - At addr = 7 with dwell = DWELL-1:
    - latched MODE = 1 and EN = 0: re-snapshot F, re-latch MODE, addr wraps to 0. Slot 7 is followed directly by slot 0, with no gap cycle.
    - latched MODE = 0: go to IDLE, DONE = 1 for exactly one cycle, BUSY = 0 in that same cycle.
  - Frame length is 8 × DWELL cycles.
- EN = 1 during SCAN: abort at the next rising edge.
  - Go to IDLE with A = 0, BUSY = 0, FRAME = 0; no DONE pulse.
  - D is high-Z immediately, combinationally.
- START while BUSY: ignored; it is not queued.
- START with EN = 1: ignored.
- F changing mid-frame: no effect on the current frame; only the snapshot is transmitted.
- MODE changing mid-frame: takes effect at the next frame boundary.
- RST_N asserted mid-frame: immediate return to reset values; no DONE pulse.

Decomposition:
- Package tdm_pkg:
  - state enum {IDLE, SCAN};
  - constants CHANNELS = 8, ADDR_W = 3, DWELL_W = 4.
- Sub-module tdm_slot_counter:
  - dwell counter plus address counter;
  - inputs: CLK, RST_N, clear, run;
  - outputs: addr[2:0], slot_end, frame_end.
- The FSM, snapshot register and output registers stay in tdm_multiplexer.

Test Plan:
- Reset with EN = 0, then release -> D = 0, A = 000, FRAME = BUSY = DONE = 0. Set EN = 1 -> D = Z.
- DWELL = 1, MODE = 0, F = 8'b1010_0110, pulse START:
  - next 8 cycles: A = 0..7 and D = 0,1,1,0,0,1,0,1;
  - FRAME high only in the first of those cycles;
  - DONE pulses in the 9th cycle, then the block is in IDLE.
- DWELL = 3, MODE = 1, F = 8'hFF, then F = 8'h00 at cycle 5:
  - frame 1 sends all ones, each address held 3 cycles;
  - frame 2 starts directly after cycle 24 and sends all zeros;
  - no DONE pulse.
- Frame in progress at A = 011, drive EN = 1 -> D = Z the same cycle; next edge A = 000, BUSY = 0, DONE never asserted.
- START pulsed again at A = 100 during a single-mode frame -> ignored; exactly one DONE pulse, 8 × DWELL cycles after the original start.
- RST_N pulsed low at A = 101 -> all outputs at reset values asynchronously; after release the block waits in IDLE until the next START.
